// File: rtl/exec_trace_buffer_if.sv
// Core retire bus and host read port of the execution trace buffer.
// The master drives retired steps and read requests. The slave is the trace buffer itself.
interface exec_trace_buffer_if #(
    parameter int DATA_W = 8,
    parameter int IR_W   = 16
);
    localparam int REC_W = IR_W + 3*DATA_W + 1;

    logic              step_valid;
    logic [DATA_W-1:0] pc;
    logic [IR_W-1:0]   ir;
    logic              mw;
    logic [DATA_W-1:0] address_out;
    logic [DATA_W-1:0] data_out;

    logic              rd_req;
    logic [REC_W-1:0]  rd_data;
    logic              rd_valid;

    modport master (
        output step_valid, pc, ir, mw, address_out, data_out, rd_req,
        input  rd_data, rd_valid
    );

    modport slave (
        input  step_valid, pc, ir, mw, address_out, data_out, rd_req,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/exec_trace_buffer.sv
// Circular capture buffer for retired-instruction records. It supports an optional PC trigger and either wraps or stops when full.
// Records are drained oldest-first through a request/valid port, but only while capture is idle or done.
module exec_trace_buffer #(
    parameter int DATA_W = 8,
    parameter int IR_W   = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              stop,
    input  logic              cfg_wrap,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_pc,
    exec_trace_buffer_if.slave bus,
    output logic [PTR_W:0]    count,
    output logic [1:0]        state,
    output logic              triggered,
    output logic              overflow
);
    localparam int REC_W = IR_W + 3*DATA_W + 1;
    localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   FULL_M1 = (PTR_W+1)'(DEPTH-1);
    localparam logic [PTR_W:0]   ONE_C   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              triggered_q, triggered_d, overflow_q, overflow_d;
    logic              wrap_q, wrap_d;
    logic [DATA_W-1:0] trig_pc_q, trig_pc_d;
    logic              rd_valid_q, rd_valid_d;
    logic [REC_W-1:0]  rd_data_q, rd_data_d;
    logic [REC_W-1:0]  mem_q [DEPTH];
    logic              wr_en;
    logic [REC_W-1:0]  step_rec;

    assign step_rec = {bus.pc, bus.ir, bus.mw, bus.address_out, bus.data_out};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        triggered_d = triggered_q;
        overflow_d  = overflow_q;
        wrap_d      = wrap_q;
        trig_pc_d   = trig_pc_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        wr_en       = 1'b0;
        if (arm) begin
            // arm overrides stop, steps and reads in the same cycle
            state_d     = trig_en ? S_ARMED : S_CAPTURE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            triggered_d = 1'b0;
            overflow_d  = 1'b0;
            wrap_d      = cfg_wrap;
            trig_pc_d   = trig_pc;
        end else begin
            unique case (state_q)
                S_ARMED: begin
                    if (bus.step_valid && bus.pc == trig_pc_q) begin
                        wr_en       = 1'b1;
                        wr_ptr_d    = wr_ptr_q + ONE_P;
                        count_d     = count_q + ONE_C;
                        triggered_d = 1'b1;
                        state_d     = S_CAPTURE;
                    end
                    if (stop) state_d = S_DONE;
                end
                S_CAPTURE: begin
                    if (bus.step_valid) begin
                        if (count_q == FULL) begin
                            // only reachable in wrap mode: drop the oldest record
                            if (wrap_q) begin
                                wr_en      = 1'b1;
                                wr_ptr_d   = wr_ptr_q + ONE_P;
                                rd_ptr_d   = rd_ptr_q + ONE_P;
                                overflow_d = 1'b1;
                            end
                        end else begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + ONE_P;
                            count_d  = count_q + ONE_C;
                            if (!wrap_q && count_q == FULL_M1) state_d = S_DONE;
                        end
                    end
                    if (stop) state_d = S_DONE;
                end
                default: begin
                    if (bus.rd_req && count_q != '0) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = mem_q[rd_ptr_q];
                        rd_ptr_d   = rd_ptr_q + ONE_P;
                        count_d    = count_q - ONE_C;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            wrap_q      <= 1'b0;
            trig_pc_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            triggered_q <= triggered_d;
            overflow_q  <= overflow_d;
            wrap_q      <= wrap_d;
            trig_pc_q   <= trig_pc_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Storage is not reset; stale entries are never readable because count gates reads.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= step_rec;
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign count        = count_q;
    assign state        = state_q;
    assign triggered    = triggered_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed scoreboard bench for exec_trace_buffer (DEPTH=4).
// Read requests queue the expected records. A negedge monitor pops and compares each rd_valid beat.
module tb_exec_trace_buffer;
    localparam int DW  = 8;
    localparam int IW  = 16;
    localparam int DEP = 4;
    localparam int PW  = 2;
    localparam int RW  = IW + 3*DW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          arm = 1'b0, stop = 1'b0, cfg_wrap = 1'b0, trig_en = 1'b0;
    logic [DW-1:0] trig_pc = '0;
    logic [PW:0]   count;
    logic [1:0]    state;
    logic          triggered, overflow;

    exec_trace_buffer_if #(.DATA_W(DW), .IR_W(IW)) bus();

    exec_trace_buffer #(.DATA_W(DW), .IR_W(IW), .DEPTH(DEP), .PTR_W(PW)) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .cfg_wrap(cfg_wrap),
        .trig_en(trig_en), .trig_pc(trig_pc), .bus(bus), .count(count),
        .state(state), .triggered(triggered), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_rec;

    function automatic logic [RW-1:0] mkrec(input logic [7:0] p);
        return {p, ~p, p, p[0], p + 8'h40, p ^ 8'h5A};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step(input logic [7:0] p);
        bus.step_valid = 1'b1;
        bus.pc = p;
        bus.ir = {~p, p};
        bus.mw = p[0];
        bus.address_out = p + 8'h40;
        bus.data_out = p ^ 8'h5A;
        @(posedge clk); #1;
        bus.step_valid = 1'b0;
    endtask

    task automatic do_arm(input logic w, input logic te, input logic [7:0] tp);
        cfg_wrap = w; trig_en = te; trig_pc = tp; arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic rd_burst(input int n);
        bus.rd_req = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            n_tot++;
            if (exp_q.size() == 0) begin
                $display("FAIL rd_unexpected got %0h expected no beat", bus.rd_data);
            end else begin
                exp_rec = exp_q.pop_front();
                if (bus.rd_data === exp_rec) n_pass++;
                else $display("FAIL rd_data got %0h expected %0h", bus.rd_data, exp_rec);
            end
        end
    end

    initial begin
        bus.step_valid = 1'b0; bus.pc = '0; bus.ir = '0; bus.mw = 1'b0;
        bus.address_out = '0; bus.data_out = '0; bus.rd_req = 1'b0;

        repeat (2) @(posedge clk); #1;
        chk("rst_state", 64'(state), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 0);
        chk("rst_rd_data", 64'(bus.rd_data), 0);
        chk("rst_triggered", 64'(triggered), 0);
        chk("rst_overflow", 64'(overflow), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // free-running capture, then drain
        do_arm(1'b0, 1'b0, 8'h00);
        chk("t1_state_capture", 64'(state), 2);
        step(8'h00); step(8'h01); step(8'h02);
        chk("t1_count", 64'(count), 3);
        chk("t1_state", 64'(state), 2);
        do_stop();
        chk("t1_state_done", 64'(state), 3);
        exp_q.push_back(mkrec(8'h00)); exp_q.push_back(mkrec(8'h01)); exp_q.push_back(mkrec(8'h02));
        rd_burst(3);
        chk("t1_count_drained", 64'(count), 0);
        @(posedge clk); #1;
        chk("t1_rd_valid_pulse", 64'(bus.rd_valid), 0);

        // no wrap: stops at full
        do_arm(1'b0, 1'b0, 8'h00);
        step(8'h10); step(8'h11); step(8'h12); step(8'h13);
        chk("t2_state_done", 64'(state), 3);
        chk("t2_count_full", 64'(count), 4);
        step(8'h14); step(8'h15);
        chk("t2_count_hold", 64'(count), 4);
        chk("t2_overflow", 64'(overflow), 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(mkrec(8'h10 + 8'(i)));
        rd_burst(5);
        chk("t2_rd_empty", 64'(bus.rd_valid), 0);
        chk("t2_count_drained", 64'(count), 0);

        // wrap: oldest records overwritten
        do_arm(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(8'h20 + 8'(i));
        do_stop();
        chk("t3_count", 64'(count), 4);
        chk("t3_overflow", 64'(overflow), 1);
        chk("t3_state", 64'(state), 3);
        for (int i = 2; i < 6; i++) exp_q.push_back(mkrec(8'h20 + 8'(i)));
        rd_burst(4);
        chk("t3_count_drained", 64'(count), 0);

        // PC trigger
        do_arm(1'b0, 1'b1, 8'h07);
        chk("t4_state_armed", 64'(state), 1);
        step(8'h05);
        chk("t4_armed_after_05", 64'(state), 1);
        chk("t4_count_dropped", 64'(count), 0);
        step(8'h06);
        step(8'h07);
        chk("t4_state_capture", 64'(state), 2);
        chk("t4_triggered", 64'(triggered), 1);
        step(8'h08);
        chk("t4_count", 64'(count), 2);
        do_stop();
        exp_q.push_back(mkrec(8'h07)); exp_q.push_back(mkrec(8'h08));
        rd_burst(2);

        // arm beats stop in the same cycle
        do_arm(1'b0, 1'b0, 8'h00);
        step(8'h30); step(8'h31); step(8'h32);
        chk("t5_count_pre", 64'(count), 3);
        arm = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0; stop = 1'b0;
        chk("t5_state", 64'(state), 2);
        chk("t5_count", 64'(count), 0);

        // asynchronous reset mid-capture
        step(8'h40); step(8'h41);
        chk("t6_count_pre", 64'(count), 2);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("t6_state", 64'(state), 0);
        chk("t6_count", 64'(count), 0);
        chk("t6_rd_valid", 64'(bus.rd_valid), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.rd_req = 1'b1;
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        chk("t6_rd_after_reset", 64'(bus.rd_valid), 0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
